// File: rtl/clk_rst_pkg.sv
// Shared definitions for the clock/reset bring-up sequencer: state encoding
// and the counter width helper.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        ST_PLL_WAIT = 3'd0,
        ST_DCM_RST  = 3'd1,
        ST_DCM_WAIT = 3'd2,
        ST_HOLD     = 3'd3,
        ST_RUN      = 3'd4,
        ST_FAIL     = 3'd5
    } seq_state_t;

    // Never returns zero so a degenerate parameter still yields a legal vector.
    function automatic int clog2w(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/clk_rst_sync2.sv
// Two-flop synchroniser for asynchronous lock-status inputs, cleared by the
// sequencer reset so a stale lock is never seen after reset release.
module clk_rst_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             mcb_drp_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge mcb_drp_clk or posedge sys_rst) begin
        if (sys_rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_rst_sequencer.sv
// Bring-up sequencer: PLL lock -> DCM reset pulse -> lock wait with retries -> hold -> run.
// Define CLK_RST_LOCK_RECOVERY_EN to re-sequence the DCMs automatically when lock drops in RUN.
module clk_rst_sequencer
    import clk_rst_pkg::*;
#(
    parameter int N_DCM          = 1,
    parameter int RST_HOLD       = 25,
    parameter int DCM_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int MAX_RETRY      = 3
) (
    input  logic                                mcb_drp_clk,
    input  logic                                sys_rst,
    input  logic                                pll_locked,
    input  logic [N_DCM-1:0]                    dcm_locked,
    input  logic                                dcm_reset_req,
    output logic [N_DCM-1:0]                    dcm_rst,
    output logic                                rst_out,
    output logic                                all_locked,
    output logic                                fail,
    output logic                                lock_lost,
    output logic [clog2w(MAX_RETRY+1)-1:0]      retry_cnt,
    output logic [2:0]                          state
);

    localparam int RST_W   = clog2w(DCM_RST_CYCLES);
    localparam int TO_W    = clog2w(LOCK_TIMEOUT);
    localparam int HOLD_W  = clog2w(RST_HOLD);
    localparam int RETRY_W = clog2w(MAX_RETRY + 1);

    seq_state_t         st;
    seq_state_t         st_nxt;
    logic               pll_sync;
    logic [N_DCM-1:0]   lock_sync;
    logic               locks_good;
    logic [RST_W-1:0]   rst_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [RETRY_W-1:0] retry_nxt;

    clk_rst_sync2 #(.WIDTH(1)) u_pll_sync (
        .mcb_drp_clk (mcb_drp_clk),
        .sys_rst     (sys_rst),
        .d           (pll_locked),
        .q           (pll_sync)
    );

    clk_rst_sync2 #(.WIDTH(N_DCM)) u_lock_sync (
        .mcb_drp_clk (mcb_drp_clk),
        .sys_rst     (sys_rst),
        .d           (dcm_locked),
        .q           (lock_sync)
    );

    assign locks_good = &lock_sync;
    assign state      = st;

    // A re-sequence request always wins over a simultaneous lock drop, so both together give one pulse.
    always_comb begin
        st_nxt    = st;
        retry_nxt = retry_cnt;
        unique case (st)
            ST_PLL_WAIT: begin
                if (pll_sync) st_nxt = ST_DCM_RST;
            end
            ST_DCM_RST: begin
                if (rst_cnt == RST_W'(DCM_RST_CYCLES - 1)) st_nxt = ST_DCM_WAIT;
            end
            ST_DCM_WAIT: begin
                if (dcm_reset_req) begin
                    st_nxt    = ST_DCM_RST;
                    retry_nxt = '0;
                end else if (locks_good) begin
                    st_nxt = ST_HOLD;
                end else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
                    // The attempt that would exceed MAX_RETRY fails; the count saturates instead of wrapping.
                    if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
                        st_nxt = ST_FAIL;
                    end else begin
                        st_nxt    = ST_DCM_RST;
                        retry_nxt = retry_cnt + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (dcm_reset_req) begin
                    st_nxt    = ST_DCM_RST;
                    retry_nxt = '0;
                end else if (!locks_good) begin
                    st_nxt = ST_DCM_RST;
                end else if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                    st_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (dcm_reset_req) begin
                    st_nxt    = ST_DCM_RST;
                    retry_nxt = '0;
                end
`ifdef CLK_RST_LOCK_RECOVERY_EN
                else if (!locks_good) begin
                    st_nxt    = ST_DCM_RST;
                    retry_nxt = '0;
                end
`endif
            end
            ST_FAIL: begin
                st_nxt = ST_FAIL;
            end
            default: begin
                st_nxt = ST_PLL_WAIT;
            end
        endcase
    end

    // Outputs are registered from the next state so they change with the state and never glitch.
    always_ff @(posedge mcb_drp_clk or posedge sys_rst) begin
        if (sys_rst) begin
            st         <= ST_PLL_WAIT;
            rst_cnt    <= '0;
            to_cnt     <= '0;
            hold_cnt   <= '0;
            retry_cnt  <= '0;
            dcm_rst    <= '1;
            rst_out    <= 1'b1;
            all_locked <= 1'b0;
            fail       <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            st         <= st_nxt;
            retry_cnt  <= retry_nxt;
            rst_cnt    <= (st == ST_DCM_RST  && st_nxt == ST_DCM_RST)  ? rst_cnt + 1'b1  : '0;
            to_cnt     <= (st == ST_DCM_WAIT && st_nxt == ST_DCM_WAIT) ? to_cnt + 1'b1   : '0;
            hold_cnt   <= (st == ST_HOLD     && st_nxt == ST_HOLD)     ? hold_cnt + 1'b1 : '0;
            dcm_rst    <= (st_nxt == ST_DCM_RST) ? '1 : '0;
            rst_out    <= (st_nxt != ST_RUN);
            all_locked <= (st_nxt == ST_RUN);
            fail       <= (st_nxt == ST_FAIL);
            if (st == ST_RUN && !locks_good) lock_lost <= 1'b1;
        end
    end

endmodule
